conv_layer_sched: RTL and testbench

//  Layer-level sequencer for the single 3x3 convolution engine. For every output filter it

---
 rtl/conv_layer_sched.sv | 177 +++++++++++++++++
 tb/tb_conv_layer_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// Layer sequencer for the 3x3 convolution engine: one engine pass per
// (filter, input channel), with incremental address generation.
module conv_layer_sched #(
    parameter int unsigned SIZE_address_pix = 13,
    parameter int unsigned SIZE_address_wei = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [4:0]                  n_in,
    input  logic [4:0]                  n_filt,
    input  logic [9:0]                  matrix2,
    input  logic [SIZE_address_pix-1:0] pix_base,
    input  logic [SIZE_address_wei-1:0] wei_base,
    input  logic [SIZE_address_pix-1:0] zap_base,
    input  logic                        STOP,
    output logic                        conv_en,
    output logic [SIZE_address_pix-1:0] memstartp,
    output logic [SIZE_address_wei-1:0] memstartw,
    output logic [SIZE_address_pix-1:0] memstartzap,
    output logic [4:0]                  lvl,
    output logic                        bias,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned PW = SIZE_address_pix;
    localparam int unsigned WW = SIZE_address_wei;
    localparam int unsigned CW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n_in_q, n_in_d;
    logic [CW-1:0] n_filt_q, n_filt_d;
    logic [9:0]    matrix2_q, matrix2_d;
    logic [PW-1:0] pix_base_q, pix_base_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] f_q, f_d;
    logic [PW-1:0] memstartp_q, memstartp_d;
    logic [WW-1:0] memstartw_q, memstartw_d;
    logic [PW-1:0] memstartzap_q, memstartzap_d;
    logic [CW-1:0] lvl_q, lvl_d;
    logic          bias_q, bias_d;
    logic          conv_en_q, conv_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] ch_nx;
    logic          last_pass;

    assign last_pass = (ch_q == n_in_q) && (f_q == n_filt_q);

    // Next-state, pass advance and registered-output values derived from the next state
    always_comb begin
        state_d       = state_q;
        n_in_d        = n_in_q;
        n_filt_d      = n_filt_q;
        matrix2_d     = matrix2_q;
        pix_base_d    = pix_base_q;
        ch_d          = ch_q;
        f_d           = f_q;
        memstartp_d   = memstartp_q;
        memstartw_d   = memstartw_q;
        memstartzap_d = memstartzap_q;
        lvl_d         = lvl_q;
        bias_d        = bias_q;
        ch_nx         = ch_q;

        if (abort && (state_q != S_IDLE)) begin
            // abort wins over STOP; configuration outputs simply hold
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_in_d        = n_in;
                        n_filt_d      = n_filt;
                        matrix2_d     = matrix2;
                        pix_base_d    = pix_base;
                        ch_d          = '0;
                        f_d           = '0;
                        memstartp_d   = pix_base;
                        memstartw_d   = wei_base;
                        memstartzap_d = zap_base;
                        lvl_d         = '0;
                        bias_d        = (n_in == '0);
                        state_d       = S_LOAD;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (STOP) begin
                        if (last_pass) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_NEXT;
                            memstartw_d = memstartw_q + WW'(1);
                            if (ch_q < n_in_q) begin
                                ch_nx       = ch_q + CW'(1);
                                memstartp_d = memstartp_q + PW'(matrix2_q);
                            end else begin
                                ch_nx         = '0;
                                f_d           = f_q + CW'(1);
                                memstartp_d   = pix_base_q;
                                memstartzap_d = memstartzap_q + PW'(matrix2_q);
                            end
                            ch_d   = ch_nx;
                            lvl_d  = ch_nx;
                            bias_d = (ch_nx == n_in_q);
                        end
                    end
                end
                S_NEXT:  state_d = S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        conv_en_d = (state_d == S_RUN);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State, latched configuration and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            n_in_q        <= '0;
            n_filt_q      <= '0;
            matrix2_q     <= '0;
            pix_base_q    <= '0;
            ch_q          <= '0;
            f_q           <= '0;
            memstartp_q   <= '0;
            memstartw_q   <= '0;
            memstartzap_q <= '0;
            lvl_q         <= '0;
            bias_q        <= 1'b0;
            conv_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_in_q        <= n_in_d;
            n_filt_q      <= n_filt_d;
            matrix2_q     <= matrix2_d;
            pix_base_q    <= pix_base_d;
            ch_q          <= ch_d;
            f_q           <= f_d;
            memstartp_q   <= memstartp_d;
            memstartw_q   <= memstartw_d;
            memstartzap_q <= memstartzap_d;
            lvl_q         <= lvl_d;
            bias_q        <= bias_d;
            conv_en_q     <= conv_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign conv_en     = conv_en_q;
    assign memstartp   = memstartp_q;
    assign memstartw   = memstartw_q;
    assign memstartzap = memstartzap_q;
    assign lvl         = lvl_q;
    assign bias        = bias_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: scoreboard of expected pass configurations,
// a simple engine model raising STOP after 20 enabled cycles.
module tb_conv_layer_sched;

    typedef struct packed {
        logic [12:0] p;
        logic [12:0] w;
        logic [12:0] z;
        logic [4:0]  lvl;
        logic        bias;
    } pass_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        STOP = 1'b0;
    logic [4:0]  n_in = '0;
    logic [4:0]  n_filt = '0;
    logic [9:0]  matrix2 = '0;
    logic [12:0] pix_base = '0;
    logic [12:0] wei_base = '0;
    logic [12:0] zap_base = '0;
    logic        conv_en;
    logic [12:0] memstartp;
    logic [12:0] memstartw;
    logic [12:0] memstartzap;
    logic [4:0]  lvl;
    logic        bias;
    logic        busy;
    logic        done;

    int    total = 0;
    int    bad = 0;
    pass_t exp_q[$];

    conv_layer_sched #(.SIZE_address_pix(13), .SIZE_address_wei(13)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .n_in(n_in), .n_filt(n_filt), .matrix2(matrix2),
        .pix_base(pix_base), .wei_base(wei_base), .zap_base(zap_base),
        .STOP(STOP), .conv_en(conv_en), .memstartp(memstartp),
        .memstartw(memstartw), .memstartzap(memstartzap), .lvl(lvl),
        .bias(bias), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({conv_en, busy, done, bias, lvl}), 0);
        check({tag, "_p"}, 32'(memstartp), 0);
        check({tag, "_w"}, 32'(memstartw), 0);
        check({tag, "_z"}, 32'(memstartzap), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_en"}, 32'(conv_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // Expected pass list computed directly from filter/channel indices
    task automatic push_layer(input int ni, input int nf, input int m2,
                              input int pb, input int wb, input int zb);
        pass_t e;
        for (int f = 0; f <= nf; f++) begin
            for (int c = 0; c <= ni; c++) begin
                e.p    = 13'(pb + c * m2);
                e.w    = 13'(wb + f * (ni + 1) + c);
                e.z    = 13'(zb + f * m2);
                e.lvl  = 5'(c);
                e.bias = (c == ni);
                exp_q.push_back(e);
            end
        end
    endtask

    // Runs one layer; abort/reset/start-glitch are injected in the given pass (0 = never)
    task automatic run_layer(input int ni, input int nf, input int m2,
                             input int pb, input int wb, input int zb,
                             input int abort_pass, input int rst_pass, input int glitch_pass);
        int    npass, seen, gap, run_cnt, cyc;
        logic  prev_en, prev_done;
        pass_t cur;
        bit    fin;
        npass = (ni + 1) * (nf + 1);
        exp_q.delete();
        push_layer(ni, nf, m2, pb, wb, zb);
        n_in = 5'(ni); n_filt = 5'(nf); matrix2 = 10'(m2);
        pix_base = 13'(pb); wei_base = 13'(wb); zap_base = 13'(zb);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_en", 32'(conv_en), 0);
        seen = 0; gap = 0; run_cnt = 0; cyc = 0;
        prev_en = 1'b0; prev_done = 1'b0; fin = 1'b0; cur = '0;
        while (!fin) begin
            tick();
            cyc++;
            if (cyc > 20000) begin
                check("timeout", 32'(cyc), 20000);
                fin = 1'b1;
            end else if (abort) begin
                check_idle("abort");
                abort = 1'b0;
                STOP = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end else if (!rst_n) begin
                check_zero("midreset");
                rst_n = 1'b1;
                STOP = 1'b0;
                start = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end else if (prev_done) begin
                check_idle("after_done");
                check("passes", 32'(seen), 32'(npass));
                check("sb_empty", 32'(exp_q.size()), 0);
                fin = 1'b1;
            end else begin
                check("busy", 32'(busy), 1);
                if (conv_en && !prev_en) begin
                    if (seen > 0) check("gap", 32'(gap), 1);
                    if (exp_q.size() == 0) begin
                        check("extra_pass", 32'(seen + 1), 32'(npass));
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    seen++;
                    run_cnt = 0;
                end
                if (conv_en) begin
                    check("cfg_p", 32'(memstartp), 32'(cur.p));
                    check("cfg_w", 32'(memstartw), 32'(cur.w));
                    check("cfg_z", 32'(memstartzap), 32'(cur.z));
                    check("cfg_lvl", 32'(lvl), 32'(cur.lvl));
                    check("cfg_bias", 32'(bias), 32'(cur.bias));
                    check("run_done", 32'(done), 0);
                    run_cnt++;
                    if (run_cnt == 20) begin
                        STOP = 1'b1;
                        if (seen == abort_pass) abort = 1'b1;
                    end
                    if (seen == rst_pass && run_cnt == 5) rst_n = 1'b0;
                    start = (seen == glitch_pass && run_cnt == 5);
                end else begin
                    STOP = 1'b0;
                    start = 1'b0;
                    if (prev_en) begin
                        gap = 1;
                        check("done_at_end", 32'(done), 32'(seen == npass));
                    end else begin
                        gap++;
                    end
                end
                prev_en = conv_en;
                prev_done = done;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("post_reset");

        // single pass, bias on first channel
        run_layer(0, 0, 16, 100, 200, 300, 0, 0, 0);
        tick();

        // six passes, spurious start pulsed during pass 1
        run_layer(2, 1, 16, 100, 200, 300, 0, 0, 1);
        tick();

        // abort together with STOP in pass 3, then a clean restart
        run_layer(2, 1, 16, 100, 200, 300, 3, 0, 0);
        tick();
        check_idle("post_abort");
        run_layer(2, 1, 16, 100, 200, 300, 0, 0, 0);
        tick();

        // STOP held while idle does nothing
        STOP = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle_stop");
        end
        STOP = 1'b0;
        tick();

        // reset asserted mid-pass 2, then a fresh layer
        run_layer(1, 1, 16, 100, 200, 300, 0, 2, 0);
        tick();
        check_zero("after_midreset");
        run_layer(1, 0, 20, 40, 50, 60, 0, 0, 0);
        tick();

        // address wrap on pixel, weight and output addresses
        run_layer(2, 1, 16, 8190, 8191, 8180, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
